// File: rtl/bmp_pkg.sv
// +----------------------------------------------------------------------------+
// | bmp_pkg : shared command encodings and register offsets for the bitmap     |
// |           placement command queue.                                         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package bmp_pkg;

  typedef enum logic [1:0] {
    OP_ADD_IMG = 2'b00,
    OP_ADD_FNT = 2'b01,
    OP_REM_IMG = 2'b10
  } cmd_op_e;

  localparam logic [1:0] REG_XLOC = 2'd0;
  localparam logic [1:0] REG_YLOC = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bmp_cmd_fifo.sv
// +----------------------------------------------------------------------------+
// | bmp_cmd_fifo : first-word-fall-through FIFO, W bits x DEPTH entries.        |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bmp_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          w_push_ok, w_pop_ok;

  assign w_pop_ok  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = push_i && ((count_q != FULL_CNT) || w_pop_ok);

  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bmp_cmd_queue.sv
// +----------------------------------------------------------------------------+
// | bmp_cmd_queue : memory-mapped X/Y/CTRL/STAT registers feeding a command    |
// |                 FIFO. Define BMP_CMD_RDBACK_EN for register readback.      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module bmp_cmd_queue
  import bmp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hC008,
  parameter int          DEPTH     = 8,
  parameter int          XW        = 10,
  parameter int          YW        = 9,
  parameter int          IDXW      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel,
  input  logic            we,
  input  logic [15:0]     addr,
  input  logic [15:0]     wdata,
  output logic [15:0]     rdata,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [1:0]      cmd_op,
  output logic [IDXW-1:0] cmd_idx,
  output logic [XW-1:0]   cmd_x,
  output logic [YW-1:0]   cmd_y,
  output logic            ovf
);

  localparam int EW = 2 + IDXW + XW + YW;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XW-1:0] xloc_q, xloc_d;
  logic [YW-1:0] yloc_q, yloc_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   w_off;
  logic          w_hit, w_wr, w_push, w_pop, w_full, w_empty;
  cmd_op_e       w_op;
  logic [EW-1:0] w_entry, w_head;
  logic [CW-1:0] w_count;
  logic          unused_ok;

  // Offset wraps for addresses below BASE, so one compare covers both bounds.
  assign w_off  = addr - BASE_ADDR;
  assign w_hit  = sel && (w_off < 16'd4);
  assign w_wr   = w_hit && we;
  assign w_push = w_wr && (w_off[1:0] == REG_CTRL);

  always_comb begin
    if (wdata[15])     w_op = OP_REM_IMG;
    else if (wdata[0]) w_op = OP_ADD_IMG;
    else               w_op = OP_ADD_FNT;
  end

  assign w_entry   = {w_op, wdata[IDXW:1], xloc_q, yloc_q};
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == FULL_CNT);
  assign cmd_valid = !w_empty;
  assign w_pop     = cmd_valid && cmd_ready;

  always_comb begin
    xloc_d = xloc_q;
    yloc_d = yloc_q;
    ovf_d  = ovf_q;
    if (w_wr && (w_off[1:0] == REG_XLOC)) xloc_d = wdata[XW-1:0];
    if (w_wr && (w_off[1:0] == REG_YLOC)) yloc_d = wdata[YW-1:0];
    if (w_wr && (w_off[1:0] == REG_STAT) && wdata[15]) begin
      ovf_d = 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xloc_q <= '0;
      yloc_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      xloc_q <= xloc_d;
      yloc_q <= yloc_d;
      ovf_q  <= ovf_d;
    end
  end

  bmp_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_entry),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign {cmd_op, cmd_idx, cmd_x, cmd_y} = w_head;
  assign ovf = ovf_q;

`ifdef BMP_CMD_RDBACK_EN
  always_comb begin
    rdata = '0;
    if (w_hit && !we) begin
      case (w_off[1:0])
        REG_XLOC: rdata[XW-1:0] = xloc_q;
        REG_YLOC: rdata[YW-1:0] = yloc_q;
        REG_STAT: begin
          rdata[15]     = ovf_q;
          rdata[14]     = w_full;
          rdata[13]     = w_empty;
          rdata[CW-1:0] = w_count;
        end
        default: rdata = '0;
      endcase
    end
  end
`else
  assign rdata = '0;
`endif

  // Upper write-data bits beyond the register fields are don't-care.
  assign unused_ok = ^wdata;

endmodule

`default_nettype wire
